// File: rtl/qspi_ram_pkg.sv
// Shared opcodes, phase encoding and decoded-command flags for the SPI/QSPI RAM target.
package qspi_ram_pkg;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_FREAD   = 8'h0B;
    localparam logic [7:0] OP_QOREAD  = 8'h6B;
    localparam logic [7:0] OP_QIOREAD = 8'hEB;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_QWRITE  = 8'h32;
    localparam logic [7:0] OP_RDID    = 8'h9F;

    typedef enum logic [2:0] {
        PH_CMD,
        PH_ADDR,
        PH_DUMMY,
        PH_DATA,
        PH_IGNORE
    } phase_e;

    typedef struct packed {
        logic is_read;
        logic quad_addr;
        logic quad_data;
        logic has_dummy;
        logic is_id;
    } cmd_flags_t;

endpackage

// File: rtl/qspi_cmd_decode.sv
// Combinational opcode decoder: classifies a command byte into the phase/width flags the target needs.
module qspi_cmd_decode
    import qspi_ram_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       valid_o,
    output cmd_flags_t flags_o
);

    always_comb begin
        valid_o = 1'b1;
        flags_o = '0;
        case (opcode_i)
            OP_READ:    flags_o.is_read = 1'b1;
            OP_FREAD: begin
                flags_o.is_read   = 1'b1;
                flags_o.has_dummy = 1'b1;
            end
            OP_QOREAD: begin
                flags_o.is_read   = 1'b1;
                flags_o.quad_data = 1'b1;
                flags_o.has_dummy = 1'b1;
            end
            OP_QIOREAD: begin
                flags_o.is_read   = 1'b1;
                flags_o.quad_addr = 1'b1;
                flags_o.quad_data = 1'b1;
                flags_o.has_dummy = 1'b1;
            end
            OP_WRITE:   flags_o = '0;
            OP_QWRITE:  flags_o.quad_data = 1'b1;
            OP_RDID: begin
                flags_o.is_read = 1'b1;
                flags_o.is_id   = 1'b1;
            end
            default:    valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/qspi_ram_slave.sv
// Parametrised SPI/QSPI RAM target: 03h/0Bh/6Bh/EBh reads, 02h/32h writes and 9Fh JEDEC ID.
// Deselect (rst_n low) ends any transaction; RAM contents persist across transactions.
module qspi_ram_slave
    import qspi_ram_pkg::*;
#(
    parameter int          RAM_ADDR_BITS = 4,
    parameter int          DUMMY_CYCLES  = 8,
    parameter logic [23:0] JEDEC_ID      = 24'hEF4015
) (
    input  logic       spi_clk,
    input  logic       rst_n,
    input  logic [3:0] spi_d_in,
    output logic [3:0] spi_d_out,
    output logic [3:0] spi_d_oe,
    output logic       quad_data,
    output logic       cmd_error
);

    localparam int         RAM_DEPTH  = 2 ** RAM_ADDR_BITS;
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

    phase_e     phase_q, phase_d;
    logic [4:0] cnt_q, cnt_d;
    logic [6:0] cmd_q, cmd_d;
    cmd_flags_t flags_q, flags_d;
    logic [23:0] addr_q, addr_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] dout_q, dout_d;
    logic [3:0] oe_q, oe_d;
    logic       quad_q, quad_d;
    logic       err_q, err_d;

    logic [7:0] ram [RAM_DEPTH];

    logic [7:0]  opcode;
    logic        opValid;
    cmd_flags_t  decFlags;
    cmd_flags_t  flags;
    logic [23:0] addrShift;
    logic [23:0] emitAddr;
    logic [2:0]  emitBit;
    logic [7:0]  srcByte;
    logic [3:0]  unitOut;
    logic        lastUnit;
    logic [23:0] advAddr;
    logic [2:0]  advBit;
    logic        ramWe;
    logic [RAM_ADDR_BITS-1:0] ramIdx;
    logic [7:0]  ramWdata;

    function automatic logic [7:0] idByte(input logic [23:0] idx);
        case (idx)
            24'd0:   return JEDEC_ID[23:16];
            24'd1:   return JEDEC_ID[15:8];
            24'd2:   return JEDEC_ID[7:0];
            default: return 8'h00;
        endcase
    endfunction

    assign opcode = {cmd_q, spi_d_in[0]};

    qspi_cmd_decode u_decode (
        .opcode_i (opcode),
        .valid_o  (opValid),
        .flags_o  (decFlags)
    );

    // During CMD the flags are not registered yet, so 9Fh must use the live decode.
    assign flags     = (phase_q == PH_CMD) ? decFlags : flags_q;
    assign addrShift = flags.quad_addr ? {addr_q[19:0], spi_d_in}
                                       : {addr_q[22:0], spi_d_in[0]};
    assign ramIdx    = addr_q[RAM_ADDR_BITS-1:0];

    // The edge that completes ADDR already needs the byte at the fully shifted address.
    always_comb begin
        emitAddr = addr_q;
        emitBit  = bit_q;
        if (phase_q == PH_ADDR) begin
            emitAddr = addrShift;
            emitBit  = 3'd0;
        end else if (phase_q != PH_DATA) begin
            emitBit = 3'd0;
        end
        srcByte = flags.is_id ? idByte(emitAddr) : ram[emitAddr[RAM_ADDR_BITS-1:0]];
        if (flags.quad_data) begin
            unitOut  = emitBit[0] ? srcByte[3:0] : srcByte[7:4];
            lastUnit = emitBit[0];
        end else begin
            unitOut  = {2'b00, srcByte[3'd7 - emitBit], 1'b0};
            lastUnit = (emitBit == 3'd7);
        end
        advAddr = emitAddr;
        advBit  = emitBit + 3'd1;
        if (lastUnit) begin
            advBit = 3'd0;
            if (!flags.is_id || emitAddr < 24'd3) begin
                advAddr = emitAddr + 24'd1;
            end
        end
    end

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        flags_d  = flags_q;
        addr_d   = addr_q;
        bit_d    = bit_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        quad_d   = quad_q;
        err_d    = err_q;
        ramWe    = 1'b0;
        ramWdata = srcByte;
        case (phase_q)
            PH_CMD: begin
                cmd_d = opcode[6:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    cnt_d   = 5'd0;
                    flags_d = decFlags;
                    if (!opValid) begin
                        phase_d = PH_IGNORE;
                        err_d   = 1'b1;
                    end else if (decFlags.is_id) begin
                        phase_d = PH_DATA;
                        dout_d  = unitOut;
                        oe_d    = 4'b0010;
                        addr_d  = advAddr;
                        bit_d   = advBit;
                    end else begin
                        phase_d = PH_ADDR;
                    end
                end
            end
            PH_ADDR: begin
                addr_d = addrShift;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == (flags.quad_addr ? 5'd5 : 5'd23)) begin
                    cnt_d = 5'd0;
                    if (flags.has_dummy) begin
                        phase_d = PH_DUMMY;
                    end else begin
                        phase_d = PH_DATA;
                        quad_d  = flags.quad_data;
                        if (flags.is_read) begin
                            dout_d = unitOut;
                            oe_d   = flags.quad_data ? 4'b1111 : 4'b0010;
                            addr_d = advAddr;
                            bit_d  = advBit;
                        end
                    end
                end
            end
            PH_DUMMY: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == DUMMY_LAST) begin
                    cnt_d   = 5'd0;
                    phase_d = PH_DATA;
                    quad_d  = flags.quad_data;
                    dout_d  = unitOut;
                    oe_d    = flags.quad_data ? 4'b1111 : 4'b0010;
                    addr_d  = advAddr;
                    bit_d   = advBit;
                end
            end
            PH_DATA: begin
                addr_d = advAddr;
                bit_d  = advBit;
                if (flags.is_read) begin
                    dout_d = unitOut;
                end else begin
                    // Each bit/nibble lands in RAM on its own edge so a cut-short byte keeps what arrived.
                    ramWe = 1'b1;
                    if (flags.quad_data) begin
                        if (bit_q[0]) ramWdata[3:0] = spi_d_in;
                        else          ramWdata[7:4] = spi_d_in;
                    end else begin
                        ramWdata[3'd7 - bit_q] = spi_d_in[0];
                    end
                end
            end
            PH_IGNORE: phase_d = PH_IGNORE;
            default:   phase_d = PH_IGNORE;
        endcase
    end

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_CMD;
            cnt_q   <= '0;
            cmd_q   <= '0;
            flags_q <= '0;
            addr_q  <= '0;
            bit_q   <= '0;
            dout_q  <= '0;
            oe_q    <= '0;
            quad_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            flags_q <= flags_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            quad_q  <= quad_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge spi_clk) begin
        if (ramWe) begin
            ram[ramIdx] <= ramWdata;
        end
    end

    assign spi_d_out = dout_q;
    assign spi_d_oe  = oe_q;
    assign quad_data = quad_q;
    assign cmd_error = err_q;

endmodule

// File: tb/tb_qspi_ram_slave.sv
// Directed bench for qspi_ram_slave: expected read bytes come from a bench-side RAM model via a queue.
module tb_qspi_ram_slave;

    logic       spi_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] spi_d_in = 4'h0;
    logic [3:0] spi_d_out;
    logic [3:0] spi_d_oe;
    logic       quad_data;
    logic       cmd_error;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [16];
    logic [7:0] expQ [$];
    logic [3:0] oeSeen = 4'h0;

    always #5 spi_clk = ~spi_clk;

    qspi_ram_slave #(
        .RAM_ADDR_BITS (4),
        .DUMMY_CYCLES  (8),
        .JEDEC_ID      (24'hEF4015)
    ) dut (
        .spi_clk   (spi_clk),
        .rst_n     (rst_n),
        .spi_d_in  (spi_d_in),
        .spi_d_out (spi_d_out),
        .spi_d_oe  (spi_d_oe),
        .quad_data (quad_data),
        .cmd_error (cmd_error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic clockBit(input logic [3:0] d);
        @(negedge spi_clk);
        spi_d_in = d;
        @(posedge spi_clk);
        #1;
        oeSeen = oeSeen | spi_d_oe;
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clockBit({3'b000, b[i]});
    endtask

    task automatic startTxn();
        @(posedge spi_clk);
        #1;
        oeSeen = 4'h0;
        rst_n  = 1'b1;
    endtask

    task automatic endTxn();
        rst_n    = 1'b0;
        spi_d_in = 4'h0;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] a);
        startTxn();
        sendByte(cmd);
        for (int i = 23; i >= 0; i--) clockBit({3'b000, a[i]});
    endtask

    task automatic writeSingle(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] idx;
        applyStimulus(8'h02, a);
        sendByte(b0);
        sendByte(b1);
        idx = a[3:0];
        model[idx] = b0;
        idx = idx + 4'd1;
        model[idx] = b1;
        checkOutput("write oe stays 0", 32'(oeSeen), 32'h0);
        endTxn();
    endtask

    task automatic pushExp(input logic [3:0] start, input int n);
        logic [3:0] idx;
        idx = start;
        for (int i = 0; i < n; i++) begin
            expQ.push_back(model[idx]);
            idx = idx + 4'd1;
        end
    endtask

    task automatic readSingle(input string tag, input int n);
        logic [7:0] obs;
        logic [7:0] exp;
        logic [3:0] other;
        for (int k = 0; k < n; k++) begin
            obs   = 8'h00;
            other = 4'h0;
            for (int b = 0; b < 8; b++) begin
                obs   = {obs[6:0], spi_d_out[1]};
                other = other | (spi_d_out & 4'b1101);
                clockBit(4'h0);
            end
            exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            checkOutput(tag, 32'(obs), 32'(exp));
            checkOutput({tag, " unused pins"}, 32'(other), 32'h0);
        end
    endtask

    task automatic readQuad(input string tag, input int n);
        logic [7:0] obs;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            obs[7:4] = spi_d_out;
            clockBit(4'h0);
            obs[3:0] = spi_d_out;
            clockBit(4'h0);
            exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            checkOutput(tag, 32'(obs), 32'(exp));
        end
    endtask

    initial begin
        logic [23:0] a;
        logic [7:0]  op;

        repeat (3) @(posedge spi_clk);
        #1;
        checkOutput("reset oe", 32'(spi_d_oe), 32'h0);
        checkOutput("reset dout", 32'(spi_d_out), 32'h0);
        checkOutput("reset quad_data", 32'(quad_data), 32'h0);
        checkOutput("reset cmd_error", 32'(cmd_error), 32'h0);

        // Single write then single read at 000003h.
        writeSingle(24'h000003, 8'hA5, 8'h3C);
        startTxn();
        sendByte(8'h03);
        a = 24'h000003;
        for (int i = 23; i >= 1; i--) clockBit({3'b000, a[i]});
        checkOutput("03h oe before edge 32", 32'(spi_d_oe), 32'h0);
        clockBit({3'b000, a[0]});
        checkOutput("03h oe at edge 32", 32'(spi_d_oe), 32'h2);
        pushExp(4'd3, 2);
        readSingle("03h read", 2);
        endTxn();

        // Quad write nibbles 1,2,3,4 then quad-output read.
        applyStimulus(8'h32, 24'h000000);
        clockBit(4'h1);
        clockBit(4'h2);
        clockBit(4'h3);
        clockBit(4'h4);
        model[0] = 8'h12;
        model[1] = 8'h34;
        checkOutput("32h oe stays 0", 32'(oeSeen), 32'h0);
        endTxn();
        applyStimulus(8'h6B, 24'h000000);
        repeat (7) clockBit(4'h0);
        checkOutput("6Bh oe during dummy", 32'(spi_d_oe), 32'h0);
        clockBit(4'h0);
        checkOutput("6Bh oe after dummy", 32'(spi_d_oe), 32'hF);
        checkOutput("6Bh quad_data", 32'(quad_data), 32'h1);
        pushExp(4'd0, 2);
        readQuad("6Bh read", 2);
        endTxn();

        // Write across the top of RAM, then quad-I/O read with wrap.
        writeSingle(24'h00000F, 8'h5A, 8'hC3);
        startTxn();
        sendByte(8'hEB);
        repeat (5) clockBit(4'h0);
        clockBit(4'hF);
        repeat (7) clockBit(4'h0);
        checkOutput("EBh oe during dummy", 32'(spi_d_oe), 32'h0);
        clockBit(4'h0);
        checkOutput("EBh oe after dummy", 32'(spi_d_oe), 32'hF);
        pushExp(4'd15, 2);
        readQuad("EBh read wrap", 2);
        endTxn();

        // 24-bit address wrap from FFFFFFh.
        applyStimulus(8'h03, 24'hFFFFFF);
        pushExp(4'd15, 2);
        readSingle("03h addr FFFFFF wrap", 2);
        endTxn();

        // JEDEC ID, then async drop of oe on deselect.
        startTxn();
        sendByte(8'h9F);
        checkOutput("9Fh oe after cmd", 32'(spi_d_oe), 32'h2);
        expQ.push_back(8'hEF);
        expQ.push_back(8'h40);
        expQ.push_back(8'h15);
        expQ.push_back(8'h00);
        expQ.push_back(8'h00);
        readSingle("9Fh id", 5);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset oe", 32'(spi_d_oe), 32'h0);
        checkOutput("async reset dout", 32'(spi_d_out), 32'h0);
        endTxn();

        // Unsupported opcode.
        startTxn();
        op = 8'h77;
        for (int i = 7; i >= 1; i--) clockBit({3'b000, op[i]});
        checkOutput("77h cmd_error before 8th edge", 32'(cmd_error), 32'h0);
        clockBit({3'b000, op[0]});
        checkOutput("77h cmd_error at 8th edge", 32'(cmd_error), 32'h1);
        repeat (32) clockBit(4'($urandom_range(0, 15)));
        checkOutput("77h cmd_error held", 32'(cmd_error), 32'h1);
        checkOutput("77h oe stays 0", 32'(oeSeen), 32'h0);
        endTxn();
        applyStimulus(8'h03, 24'h000003);
        pushExp(4'd3, 2);
        readSingle("RAM after 77h", 2);
        endTxn();

        // Partial write cut short by deselect.
        writeSingle(24'h000005, 8'h6C, 8'h81);
        applyStimulus(8'h02, 24'h000005);
        clockBit(4'h1);
        clockBit(4'h0);
        clockBit(4'h1);
        clockBit(4'h1);
        model[5] = {4'b1011, model[5][3:0]};
        checkOutput("partial write oe", 32'(oeSeen), 32'h0);
        endTxn();
        applyStimulus(8'h03, 24'h000004);
        pushExp(4'd4, 3);
        readSingle("read after partial write", 3);
        endTxn();

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
